// File: rtl/lza_normalizer.sv
// Post-LZA normalizer: shifts the adder sum by the anticipated count, fixes a one-short estimate
// and adjusts the exponent. Optional LZA_NORM_ERRCNT_EN adds the err_count correction counter.
module lza_normalizer #(
  parameter int CSIG_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CSIG_WIDTH:0]   in_sum,
  input  logic [5:0]            in_ld_count,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  input  logic                  in_sign,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CSIG_WIDTH:0]   out_sig,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic                  out_sign,
  output logic                  out_zero,
  output logic                  out_underflow,
  output logic                  out_corr
`ifdef LZA_NORM_ERRCNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  localparam int          LP_MAX_INT = (CSIG_WIDTH > 63) ? 63 : CSIG_WIDTH;
  localparam logic [5:0]  LP_MAX_SH  = 6'(LP_MAX_INT);

  logic                  w_s1_adv;
  logic                  w_s2_adv;
  logic [5:0]            w_s1_sh;
  logic [CSIG_WIDTH:0]   w_s1_shifted;
  logic                  w_s1_zero;

  logic                  r_s1_valid;
  logic [CSIG_WIDTH:0]   r_s1_sig;
  logic [5:0]            r_s1_sh;
  logic [EXP_WIDTH-1:0]  r_s1_exp;
  logic                  r_s1_sign;
  logic                  r_s1_zero;

  logic                  w_corr;
  logic [CSIG_WIDTH:0]   w_s2_sig;
  logic [EXP_WIDTH:0]    w_total;
  logic [EXP_WIDTH:0]    w_exp_ext;
  logic [EXP_WIDTH:0]    w_exp_diff;
  logic [EXP_WIDTH-1:0]  w_s2_exp;
  logic                  w_s2_uf;

  logic                  r_s2_valid;
  logic [CSIG_WIDTH:0]   r_out_sig;
  logic [EXP_WIDTH-1:0]  r_out_exp;
  logic                  r_out_sign;
  logic                  r_out_zero;
  logic                  r_out_uf;
  logic                  r_out_corr;

  // A stage may load when it is empty or when its content moves on in the same cycle.
  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    w_s1_sh = in_ld_count;
    if (in_ld_count > LP_MAX_SH) begin
      w_s1_sh = LP_MAX_SH;
    end
  end

  assign w_s1_shifted = in_sum << w_s1_sh;
  assign w_s1_zero    = (in_sum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sig   <= '0;
      r_s1_sh    <= '0;
      r_s1_exp   <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sig  <= w_s1_shifted;
        r_s1_sh   <= w_s1_sh;
        r_s1_exp  <= in_exp;
        r_s1_sign <= in_sign;
        r_s1_zero <= w_s1_zero;
      end
    end
  end

  // The anticipator may be one short: a clear MSB on a nonzero sum needs one more shift.
  assign w_corr     = ~r_s1_zero & ~r_s1_sig[CSIG_WIDTH];
  assign w_s2_sig   = w_corr ? (r_s1_sig << 1) : r_s1_sig;
  assign w_total    = (EXP_WIDTH+1)'(r_s1_sh) + (EXP_WIDTH+1)'(w_corr);
  assign w_exp_ext  = {1'b0, r_s1_exp};
  assign w_exp_diff = w_exp_ext - w_total;

  always_comb begin
    w_s2_uf  = 1'b0;
    w_s2_exp = '0;
    if (!r_s1_zero) begin
      if (w_exp_ext <= w_total) begin
        w_s2_uf = 1'b1;
      end else begin
        w_s2_exp = w_exp_diff[EXP_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_sig  <= '0;
      r_out_exp  <= '0;
      r_out_sign <= 1'b0;
      r_out_zero <= 1'b0;
      r_out_uf   <= 1'b0;
      r_out_corr <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sig  <= w_s2_sig;
        r_out_exp  <= w_s2_exp;
        r_out_sign <= r_s1_sign;
        r_out_zero <= r_s1_zero;
        r_out_uf   <= w_s2_uf;
        r_out_corr <= w_corr;
      end
    end
  end

  assign out_valid     = r_s2_valid;
  assign out_sig       = r_out_sig;
  assign out_exp       = r_out_exp;
  assign out_sign      = r_out_sign;
  assign out_zero      = r_out_zero;
  assign out_underflow = r_out_uf;
  assign out_corr      = r_out_corr;

`ifdef LZA_NORM_ERRCNT_EN
  logic [15:0] r_err_count;

  // Counts delivered beats that needed the correction shift; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (r_s2_valid & out_ready & r_out_corr & (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_lza_normalizer.sv
// Scoreboard bench for lza_normalizer: directed cases, backpressure, mid-flight reset
// and randomized beats checked against an arithmetic reference model.
module tb_lza_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_sum;
  logic [5:0]  in_ld_count;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sig;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_underflow;
  logic        out_corr;
`ifdef LZA_NORM_ERRCNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  lza_normalizer #(.CSIG_WIDTH(23), .EXP_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_ld_count   (in_ld_count),
    .in_exp        (in_exp),
    .in_sign       (in_sign),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sig       (out_sig),
    .out_exp       (out_exp),
    .out_sign      (out_sign),
    .out_zero      (out_zero),
    .out_underflow (out_underflow),
`ifdef LZA_NORM_ERRCNT_EN
    .err_count     (err_count),
`endif
    .out_corr      (out_corr)
  );

  typedef struct packed {
    logic [23:0] sig;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic        uf;
    logic        corr;
  } beat_t;

  typedef struct {
    beat_t b;
    int    tIssue;
    bit    chkLat;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  sbEntry_t monE;
  beat_t    curOut;
  beat_t    prevBeat;
  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  int       acceptCnt = 0;
  int       outCount = 0;
  int       expErr = 0;
  bit       randReady = 1'b0;
  bit       chkLatNext = 1'b0;
  bit       prevHold = 1'b0;
  bit       rstFlag = 1'b0;

  assign curOut = {out_sig, out_exp, out_sign, out_zero, out_underflow, out_corr};

  // Reference built from integer arithmetic: multiply by 2^sh modulo the significand range.
  function automatic beat_t refModel(input logic [23:0] sum, input logic [5:0] ld,
                                     input logic [7:0] e, input logic s);
    beat_t  r;
    int     sh;
    longint v;
    int     total;
    sh = (int'(ld) > 23) ? 23 : int'(ld);
    v = (longint'(sum) * (longint'(1) << sh)) % 64'sd16777216;
    r.zero = (sum == 24'd0);
    r.corr = !r.zero && (v < 64'sd8388608);
    if (r.corr) v = (v * 2) % 64'sd16777216;
    r.sig  = v[23:0];
    total  = sh + (r.corr ? 1 : 0);
    r.sign = s;
    r.uf   = 1'b0;
    r.exp  = 8'd0;
    if (!r.zero) begin
      if (int'(e) - total <= 0) r.uf = 1'b1;
      else r.exp = 8'(int'(e) - total);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h required=%0h", name, got, want);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge rst_n) rstFlag = 1'b1;

  always @(posedge clk) begin
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every handshake and checks stalled outputs stay put.
  always @(negedge clk) begin
    if (rst_n && !rstFlag) begin
      if (prevHold) begin
        checks++;
        if (!out_valid || curOut !== prevBeat) begin
          errors++;
          $display("[TB] FAIL hold: valid=%0b out=%h required valid=1 out=%h", out_valid, curOut, prevBeat);
        end
      end
      if (out_valid && out_ready) begin
        outCount++;
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected beat: got=%h required=no beat", curOut);
        end else begin
          monE = sbQ.pop_front();
          if (curOut !== monE.b) begin
            errors++;
            $display("[TB] FAIL beat: got sig=%h exp=%0d sign=%0b zero=%0b uf=%0b corr=%0b required sig=%h exp=%0d sign=%0b zero=%0b uf=%0b corr=%0b",
                     out_sig, out_exp, out_sign, out_zero, out_underflow, out_corr,
                     monE.b.sig, monE.b.exp, monE.b.sign, monE.b.zero, monE.b.uf, monE.b.corr);
          end
          if (monE.b.corr) expErr++;
          if (monE.chkLat) begin
            checks++;
            if (cyc - monE.tIssue != 2) begin
              errors++;
              $display("[TB] FAIL latency: got=%0d required=2", cyc - monE.tIssue);
            end
          end
        end
      end
    end
    prevHold = rst_n && out_valid && !out_ready;
    prevBeat = curOut;
    rstFlag  = 1'b0;
  end

  // Presents one beat, waits for acceptance and records its expected result.
  task automatic applyStimulus(input logic [23:0] sum, input logic [5:0] ld,
                               input logic [7:0] e, input logic s);
    sbEntry_t ent;
    bit accepted = 1'b0;
    in_sum = sum;
    in_ld_count = ld;
    in_exp = e;
    in_sign = s;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ent.b = refModel(sum, ld, e, s);
        ent.tIssue = cyc;
        ent.chkLat = chkLatNext;
        sbQ.push_back(ent);
        acceptCnt++;
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: got in_ready=0 required=1");
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: got pending=%0d required=0", sbQ.size());
      sbQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomBeat();
    int          lz;
    int          r;
    logic [23:0] top;
    logic [23:0] sum;
    logic [5:0]  ld;
    logic [7:0]  e;
    lz = $urandom_range(0, 24);
    if (lz == 24) begin
      sum = 24'd0;
    end else begin
      top = 24'h800000 >> lz;
      sum = top | (24'($urandom) & (top - 24'd1));
    end
    r = $urandom_range(0, 99);
    if (r < 50) ld = 6'(lz);
    else if (r < 85) ld = (lz > 0) ? 6'(lz - 1) : 6'd0;
    else ld = 6'($urandom_range(0, 63));
    e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
    applyStimulus(sum, ld, e, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int a0;
    int oc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sum = '0;
    in_ld_count = '0;
    in_exp = '0;
    in_sign = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst out_sig", 32'(out_sig), 32'd0);
    checkOutput("rst out_exp", 32'(out_exp), 32'd0);
    checkOutput("rst flags", {28'd0, out_sign, out_zero, out_underflow, out_corr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    $display("[TB] directed cases");
    chkLatNext = 1'b1;
    applyStimulus(24'h010000, 6'd7, 8'd100, 1'b0);
    waitDrain();
    applyStimulus(24'h010000, 6'd6, 8'd100, 1'b1);
    waitDrain();
    applyStimulus(24'h000000, 6'd23, 8'd50, 1'b0);
    waitDrain();
    applyStimulus(24'h000001, 6'd23, 8'd10, 1'b1);
    waitDrain();
    applyStimulus(24'h000100, 6'd40, 8'd200, 1'b0);
    waitDrain();
    applyStimulus(24'h400000, 6'd0, 8'd1, 1'b0);
    waitDrain();
    chkLatNext = 1'b0;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    a0 = acceptCnt;
    fork
      begin
        applyStimulus(24'h123456, 6'd3, 8'd90, 1'b0);
        applyStimulus(24'h00F000, 6'd7, 8'd91, 1'b1);
        applyStimulus(24'h000ABC, 6'd11, 8'd92, 1'b0);
        applyStimulus(24'h800000, 6'd0, 8'd93, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("stall accepted", 32'(acceptCnt - a0), 32'd2);
        checkOutput("stall in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] random beats");
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      randomBeat();
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset with beats in flight");
    out_ready = 1'b0;
    applyStimulus(24'h00FFFF, 6'd8, 8'd60, 1'b0);
    applyStimulus(24'h0000FF, 6'd16, 8'd61, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_sig", 32'(out_sig), 32'd0);
    sbQ.delete();
    expErr = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    oc = outCount;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post-reset beats", 32'(outCount - oc), 32'd0);

    applyStimulus(24'h010000, 6'd6, 8'd100, 1'b0);
    waitDrain();
`ifdef LZA_NORM_ERRCNT_EN
    checkOutput("err_count", 32'(err_count), 32'(expErr));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
